nios2_char_out: RTL and testbench

//  Avalon-MM slave output port for the Nios II system. It drives game-side

---
 rtl/nios2_char_out.sv | 129 ++++++++++++
 tb/tb_nios2_char_out.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_char_out.sv
`default_nettype none
// ============================================================================
// Module   : nios2_char_out
// Purpose  : Avalon-MM slave output port. CPU writes drive a level data
//            register with atomic set/clear, plus a self-timed pulse that
//            drops masked bits after PULSE_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_char_out #(
   parameter int              WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int              PULSE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   // Counter only needs to hold PULSE_CYCLES, so it can never wrap.
   localparam int CW = $clog2(PULSE_CYCLES + 1);

   localparam logic [CW-1:0] c_CNT_LOAD = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

   localparam logic [2:0] c_ADDR_DATA     = 3'd0;
   localparam logic [2:0] c_ADDR_PULSE    = 3'd1;
   localparam logic [2:0] c_ADDR_BUSY     = 3'd2;
   localparam logic [2:0] c_ADDR_CNT      = 3'd3;
   localparam logic [2:0] c_ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] c_ADDR_OUTCLEAR = 3'd5;

   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_mask;
   logic [CW-1:0]    r_cnt;
   logic [31:0]      r_readdata;

   logic             w_wr;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_data_nxt;
   logic [WIDTH-1:0] w_mask_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [31:0]      w_rd_nxt;
   logic             w_unused;

   assign w_wr     = chipselect & ~write_n;
   assign w_wd     = writedata[WIDTH-1:0];
   // Upper writedata bits are intentionally ignored.
   assign w_unused = &{1'b0, writedata};

   // Next-state: timer decrement and expiry first, then the CPU write
   // overrides it (write has priority over expiry).
   always_comb begin
      w_data_nxt = r_data;
      w_mask_nxt = r_mask;
      w_cnt_nxt  = r_cnt;

      if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - c_CNT_ONE;
         if (r_cnt == c_CNT_ONE) begin
            w_data_nxt = r_data & ~r_mask;
            w_mask_nxt = '0;
         end
      end

      if (w_wr) begin
         case (address)
            c_ADDR_DATA: begin
               w_data_nxt = w_wd;
               w_mask_nxt = '0;
               w_cnt_nxt  = '0;
            end
            c_ADDR_PULSE: begin
               // Reload discards any expiry happening this cycle.
               if (w_wd != '0) begin
                  w_data_nxt = r_data | w_wd;
                  w_mask_nxt = r_mask | w_wd;
                  w_cnt_nxt  = c_CNT_LOAD;
               end
            end
            c_ADDR_OUTSET: begin
               w_data_nxt = w_data_nxt | w_wd;
            end
            c_ADDR_OUTCLEAR: begin
               w_data_nxt = w_data_nxt & ~w_wd;
               w_mask_nxt = w_mask_nxt & ~w_wd;
            end
            default: begin
            end
         endcase
      end
   end

   // Read mux: zero-extended register views selected by address.
   always_comb begin
      w_rd_nxt = '0;
      case (address)
         c_ADDR_DATA:  w_rd_nxt = 32'(r_data);
         c_ADDR_PULSE: w_rd_nxt = 32'(r_mask);
         c_ADDR_BUSY:  w_rd_nxt = {31'b0, (r_cnt != '0)};
         c_ADDR_CNT:   w_rd_nxt = 32'(r_cnt);
         default:      w_rd_nxt = '0;
      endcase
   end

   // Register state; reset aborts any pulse in progress immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data     <= RESET_VALUE;
         r_mask     <= '0;
         r_cnt      <= '0;
         r_readdata <= '0;
      end else begin
         r_data     <= w_data_nxt;
         r_mask     <= w_mask_nxt;
         r_cnt      <= w_cnt_nxt;
         r_readdata <= w_rd_nxt;
      end
   end

   assign out_port = r_data;
   assign readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_nios2_char_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_char_out
// Purpose  : Self-checking bench for nios2_char_out with a deadline-based
//            reference model (pulse end expressed as an absolute edge number).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_char_out;

   localparam int         WIDTH = 8;
   localparam logic [7:0] RV    = 8'h3C;
   localparam int         P     = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int checks = 0;
   int failures = 0;

   // Reference model: level data, mask, and absolute edge at which the
   // pulse ends (0 = no pulse). e = number of edges completed so far.
   logic [7:0]  m_data = RV;
   logic [7:0]  m_mask = '0;
   int          m_deadline = 0;
   int          e = 0;
   logic [31:0] m_rd = '0;

   nios2_char_out #(
      .WIDTH        (WIDTH),
      .RESET_VALUE  (RV),
      .PULSE_CYCLES (P)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   function automatic int remaining();
      return (m_deadline > e) ? (m_deadline - e) : 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return {24'b0, m_data};
         3'd1:    return {24'b0, m_mask};
         3'd2:    return {31'b0, remaining() != 0};
         3'd3:    return 32'(remaining());
         default: return 32'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model across one clock edge with the given bus inputs.
   task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn,
                             input logic [7:0] wd);
      logic wr;
      logic expire;
      wr = cs && !wn;
      m_rd = reset ? 32'b0 : model_read(a);
      if (reset) begin
         e++;
         return;
      end
      expire = (m_deadline != 0) && (m_deadline == e + 1);
      if (wr && a == 3'd0) begin
         m_data = wd; m_mask = '0; m_deadline = 0;
      end else if (wr && a == 3'd1 && wd != 0) begin
         m_data = m_data | wd; m_mask = m_mask | wd; m_deadline = e + 1 + P;
      end else begin
         if (expire) begin
            m_data = m_data & ~m_mask; m_mask = '0; m_deadline = 0;
         end
         if (wr && a == 3'd4) m_data = m_data | wd;
         if (wr && a == 3'd5) begin
            m_data = m_data & ~wd; m_mask = m_mask & ~wd;
         end
      end
      e++;
   endtask

   // One bus cycle: drive, clock, then compare out_port and readdata.
   task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd);
      address = a; chipselect = cs; write_n = wn; writedata = wd;
      @(posedge clk);
      model_edge(a, cs, wn, wd[7:0]);
      #1;
      check("out_port", {24'b0, out_port}, {24'b0, m_data});
      check("readdata", readdata, m_rd);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd);
      cyc(a, 1'b1, 1'b0, wd);
   endtask

   task automatic idle(input logic [2:0] a);
      cyc(a, 1'b0, 1'b1, $urandom);
   endtask

   // Asynchronous reset pulse, checked before any clock edge arrives.
   task automatic do_reset();
      reset = 1'b1;
      m_data = RV; m_mask = '0; m_deadline = 0;
      #1;
      check("rst_out_port", {24'b0, out_port}, {24'b0, RV});
      check("rst_readdata", readdata, 32'b0);
      @(posedge clk);
      model_edge(3'd0, 1'b0, 1'b1, 8'h00);
      #1;
      reset = 1'b0;
      idle(3'd2);
      check("rst_busy", readdata, 32'b0);
   endtask

   initial begin
      // Reset held from time zero, then released.
      @(posedge clk); model_edge(3'd0, 1'b0, 1'b1, 8'h00); #1;
      check("init_out_port", {24'b0, out_port}, {24'b0, RV});
      check("init_readdata", readdata, 32'b0);
      reset = 1'b0;
      idle(3'd0);

      // Mid-run reset.
      wr(3'd0, 32'h0000_0055);
      do_reset();

      // DATA write and read-back latency.
      wr(3'd0, 32'hFFFF_FFA5);
      check("data_a5", {24'b0, out_port}, 32'h0000_00A5);
      idle(3'd0);
      check("read_a5", readdata, 32'h0000_00A5);

      // Single pulse, counter observed on address 3.
      wr(3'd0, 32'h0);
      wr(3'd1, 32'h01);
      for (int i = 0; i < 6; i++) idle(3'd3);
      check("pulse_done", {24'b0, out_port}, 32'h0);

      // Re-trigger extends both bits.
      wr(3'd1, 32'h01);
      idle(3'd1);
      wr(3'd1, 32'h02);
      idle(3'd1);
      check("retrig_mask", readdata, 32'h03);
      for (int i = 0; i < 5; i++) idle(3'd1);
      check("retrig_done", {24'b0, out_port}, 32'h0);

      // DATA write on the expiry cycle.
      wr(3'd1, 32'h01);
      for (int i = 0; i < P - 1; i++) idle(3'd3);
      wr(3'd0, 32'hFF);
      idle(3'd1);
      check("coll_data", {24'b0, out_port}, 32'hFF);
      check("coll_mask", readdata, 32'h0);

      // OUTSET on the expiry cycle keeps the bit high.
      wr(3'd0, 32'h0);
      wr(3'd1, 32'h01);
      for (int i = 0; i < P - 1; i++) idle(3'd0);
      wr(3'd4, 32'h01);
      idle(3'd2);
      check("coll_outset", {24'b0, out_port}, 32'h01);

      // Set/clear and ignored address.
      wr(3'd0, 32'h0);
      wr(3'd4, 32'h0F);
      wr(3'd5, 32'h05);
      check("set_clr", {24'b0, out_port}, 32'h0A);
      wr(3'd6, 32'hFF);
      check("addr6", {24'b0, out_port}, 32'h0A);

      // Reset while cnt = 2 aborts the pulse.
      wr(3'd1, 32'hC1);
      idle(3'd3);
      idle(3'd3);
      do_reset();

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] wd;
         wd = $urandom;
         if ($urandom_range(0, 3) == 0) wd = wd & 32'hFFFF_FF00;
         cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 2) == 0), wd);
         if (i % 200 == 199) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
